ahb_latency_ram: RTL and testbench
==================================

# ahb_latency_ram

AHB-Lite subordinate RAM for the uncore, occupying the UNCORE_RAM_BASE/RANGE window and sized and timed entirely from the cvw_t configuration. It inserts a programmable number of wait states per transfer (P.RAM_LATENCY) to stress the LSU/IFU bus interfaces. Optionally it serves SEQ burst beats without wait states (P.BURST_EN behaviour). It sits directly downstream of the AHB decoder/multiplexer and upstream of nothing; its HREADRam/HREADYRam/HRESPRam feed the subordinate mux.

## Interface
- P, cvw_t, global configuration: uses AHBW, PA_BITS, RAM_LATENCY, BURST_EN, UNCORE_RAM_RANGE.
- RANGE, P.UNCORE_RAM_RANGE, byte-range mask; depth = (RANGE+1)/(AHBW/8) words.
- HCLK  in  1  clock; all state updates on rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- HSELRam  in  1  decoder select for this window.
- HADDR  in  P.PA_BITS  address-phase byte address.
- HWRITE  in  1  address-phase write flag.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HREADY  in  1  global bus ready (mux output).
- HWDATA  in  P.AHBW  data-phase write data.
- HWSTRB  in  P.AHBW/8  data-phase byte strobes.
- HREADRam  out  P.AHBW  read data.
- HREADYRam  out  1  subordinate ready.
- HRESPRam  out  1  always 0 (OKAY).

## Operation
- Accept: transfer accepted when HSELRam & HREADY & HTRANS[1]; capture word address (HADDR above log2(AHBW/8) bits, masked by RANGE), HWRITE, and whether HTRANS==SEQ.
- FSM: IDLE (no data phase), WAIT (counter > 0, HREADYRam=0), DONE (final data-phase cycle, HREADYRam=1).
- On accept: if latency applies and P.RAM_LATENCY>0, go WAIT with counter=P.RAM_LATENCY; else go DONE. WAIT decrements each cycle, moves to DONE on cycle where counter reaches 1. DONE: if new accept, re-enter per above; else IDLE.
- Latency applies to every accepted transfer, except SEQ beats when burst is compiled in (see Configuration).
- Reads: storage read with address-phase address; result loaded into HREADRam register on accept and held until the next accepted read.
- Writes: committed at the clock edge ending DONE, using HWDATA masked per-byte by HWSTRB.
- Forwarding: if a read is accepted in the same cycle a write to the same word commits, HREADRam takes old word with HWSTRB-enabled bytes replaced by HWDATA.
- IDLE/BUSY or unselected: no state change, HREADYRam=1, zero-wait OKAY.
- Counter width: clog2(P.RAM_LATENCY+1), min 1 bit; no wrap.
- Out-of-range addresses: aliased by RANGE mask, no error.

## Timing
- Reset values: HREADYRam=1, HRESPRam=0, HREADRam=0, FSM=IDLE, counter=0, no pending write.
- Reset asserted mid-transfer: pending transfer dropped, no write committed, outputs at reset values next cycle. Memory contents are not cleared.
- NONSEQ accepted at cycle T, latency L: HREADYRam=0 for cycles T+1..T+L, 1 at T+L+1; read data valid at T+L+1.
- L=0: HREADYRam never deasserts; back-to-back transfers every cycle.
- HREADYRam is a registered output, with no combinational path from inputs.

## Configuration
- AHB_RAM_BURST_EN defined: SEQ beats accepted while in DONE of the same burst take zero wait states. Applies only when P.BURST_EN=1; otherwise identical to undefined.
- Undefined: SEQ treated as NONSEQ, full P.RAM_LATENCY per beat. No burst logic synthesized.

## Structure
- HTRANS encodings (AHB_IDLE, AHB_BUSY, AHB_NONSEQ, AHB_SEQ) are shared constants in the cvw package, not local.
- FSM state enum is local.
- Storage in existing sub-module ram1p1rwbe: width AHBW, depth from RANGE, byte enables.

## Test plan
- L=3, NONSEQ read 0x80000010 after reset: HREADYRam low 3 cycles, then high with HREADRam = preload word; HRESPRam=0 throughout.
- L=0, write 0xDEADBEEF_CAFEF00D strobe 0x0F to word 2, then read word 2 next cycle: forwarded data low 32 bits 0xCAFEF00D, upper bytes old.
- L=2, INCR4 burst (NONSEQ + 3 SEQ): with AHB_RAM_BURST_EN and BURST_EN=1, total 2+4 data cycles; without the macro, 12 cycles.
- HRESETn low during WAIT of a write to word 5: HREADYRam=1 next cycle; subsequent read of word 5 returns pre-write value.
- IDLE/BUSY/HSELRam=0 cycles interleaved: HREADYRam stays 1, no memory change.
- Address with bits above RANGE set reads same word as masked address.

Source files
------------

// File: rtl/ahb_latency_ram_pkg.sv
// Shared configuration record, AHB transfer encodings and sizing helpers for the latency RAM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ahb_latency_ram_pkg;

   // Global configuration record; the RAM reads only the fields it needs.
   typedef struct packed {
      int          AHBW;
      int          PA_BITS;
      int          RAM_LATENCY;
      logic        BURST_EN;
      logic [63:0] UNCORE_RAM_RANGE;
   } cvw_t;

   // HTRANS encodings shared by every AHB agent.
   localparam logic [1:0] AHB_IDLE   = 2'b00;
   localparam logic [1:0] AHB_BUSY   = 2'b01;
   localparam logic [1:0] AHB_NONSEQ = 2'b10;
   localparam logic [1:0] AHB_SEQ    = 2'b11;

   localparam cvw_t RAM_DEFAULT_CFG = '{AHBW: 64, PA_BITS: 32, RAM_LATENCY: 3,
                                        BURST_EN: 1'b1, UNCORE_RAM_RANGE: 64'hFF};

   // Wait-state counter width: wide enough to hold the latency, never narrower than 1 bit.
   function automatic int cnt_bits(input int lat);
      return (lat > 0) ? $clog2(lat + 1) : 1;
   endfunction

endpackage

// File: rtl/ahb_latency_ram_ram1p1rwbe.sv
// Word storage: combinational read port, byte-enabled write port committed on the clock edge.
// Latency: read is same-cycle, write lands at the next rising edge.
// Backpressure: none; contents have no reset and survive bus resets.
module ram1p1rwbe #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic               clk,
   input  logic [AW-1:0]      raddr,
   output logic [WIDTH-1:0]   rdata,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [WIDTH/8-1:0] wbe,
   input  logic [WIDTH-1:0]   wdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[raddr];

   // Byte-lane write: only strobed bytes of the addressed word change.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < WIDTH/8; b++) begin
            if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/ahb_latency_ram.sv
// AHB-Lite subordinate RAM that inserts P.RAM_LATENCY wait states per accepted transfer (macro AHB_RAM_BURST_EN: zero-wait SEQ beats).
// Latency: NONSEQ accepted at T -> HREADYRam low T+1..T+L, data phase completes at T+L+1; L=0 gives back-to-back transfers.
// Backpressure: HREADYRam is a registered output, low only while counting wait states; IDLE/BUSY/unselected see zero-wait OKAY.
module ahb_latency_ram
   import ahb_latency_ram_pkg::*;
#(
   parameter cvw_t P = RAM_DEFAULT_CFG
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSELRam,
   input  logic [P.PA_BITS-1:0]  HADDR,
   input  logic                  HWRITE,
   input  logic [1:0]            HTRANS,
   input  logic                  HREADY,
   input  logic [P.AHBW-1:0]     HWDATA,
   input  logic [P.AHBW/8-1:0]   HWSTRB,
   output logic [P.AHBW-1:0]     HREADRam,
   output logic                  HREADYRam,
   output logic                  HRESPRam
);

   localparam int WBYTES = P.AHBW / 8;
   localparam int OFFW   = $clog2(WBYTES);
   localparam int DEPTH  = (int'(P.UNCORE_RAM_RANGE) + 1) / WBYTES;
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW     = cnt_bits(P.RAM_LATENCY);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              hready_q, hready_d;
   logic [P.AHBW-1:0] rdata_q, rdata_d;
   logic              wr_q, wr_d;
   logic [AW-1:0]     waddr_q, waddr_d;

   logic [P.PA_BITS-1:0] haddr_masked;
   logic [AW-1:0]        word_addr;
   logic [P.AHBW-1:0]    mem_rdata;
   logic [P.AHBW-1:0]    fwd_word;
   logic                 accept, commit, fwd_hit, burst_beat;
   logic                 unused_bits;

   // Addresses outside the window alias onto it through the range mask.
   assign haddr_masked = HADDR & P.UNCORE_RAM_RANGE[P.PA_BITS-1:0];
   assign word_addr    = haddr_masked[OFFW +: AW];
   assign unused_bits  = ^{haddr_masked, HTRANS[0]};

   assign accept  = HSELRam & HREADY & HTRANS[1];
   assign commit  = (state_q == ST_DONE) & wr_q;
   assign fwd_hit = commit & (waddr_q == word_addr);

`ifdef AHB_RAM_BURST_EN
   assign burst_beat = P.BURST_EN & (HTRANS == AHB_SEQ) & (state_q == ST_DONE);
`else
   assign burst_beat = 1'b0;
`endif

   ram1p1rwbe #(.WIDTH(P.AHBW), .DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk   (HCLK),
      .raddr (word_addr),
      .rdata (mem_rdata),
      .we    (commit & HRESETn),
      .waddr (waddr_q),
      .wbe   (HWSTRB),
      .wdata (HWDATA)
   );

   // Old word with the committing write's strobed bytes overlaid, for same-word read-after-write.
   always_comb begin
      fwd_word = mem_rdata;
      for (int b = 0; b < WBYTES; b++) begin
         if (HWSTRB[b]) fwd_word[b*8 +: 8] = HWDATA[b*8 +: 8];
      end
   end

   // Next-state: count wait states, then a single DONE cycle that may chain straight into the next transfer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      waddr_d = waddr_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_WAIT: begin
            if (cnt_q == CW'(1)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            if (accept) begin
               if ((P.RAM_LATENCY > 0) && !burst_beat) begin
                  state_d = ST_WAIT;
                  cnt_d   = CW'(P.RAM_LATENCY);
               end else begin
                  state_d = ST_DONE;
                  cnt_d   = '0;
               end
               wr_d    = HWRITE;
               waddr_d = word_addr;
               if (!HWRITE) rdata_d = fwd_hit ? fwd_word : mem_rdata;
            end else begin
               state_d = ST_IDLE;
               wr_d    = 1'b0;
            end
         end
      endcase
      hready_d = (state_d != ST_WAIT);
   end

   // State registers with synchronous active-low reset; reset drops any pending write.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         hready_q <= 1'b1;
         rdata_q  <= '0;
         wr_q     <= 1'b0;
         waddr_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hready_q <= hready_d;
         rdata_q  <= rdata_d;
         wr_q     <= wr_d;
         waddr_q  <= waddr_d;
      end
   end

   assign HREADRam  = rdata_q;
   assign HREADYRam = hready_q;
   assign HRESPRam  = 1'b0;

endmodule

// File: tb/tb_ahb_latency_ram.sv
// Directed bench: three RAM instances (latency 3, 0, 2) on one bus, HREADY muxed from the active one.
// Latency: transfers driven on negedge, outputs sampled on negedge.
// Backpressure: the master holds each address phase until the active RAM reports ready.
module tb_ahb_latency_ram;
   import ahb_latency_ram_pkg::*;

   localparam cvw_t CFG_L3 = '{AHBW: 64, PA_BITS: 32, RAM_LATENCY: 3, BURST_EN: 1'b1, UNCORE_RAM_RANGE: 64'hFF};
   localparam cvw_t CFG_L0 = '{AHBW: 64, PA_BITS: 32, RAM_LATENCY: 0, BURST_EN: 1'b1, UNCORE_RAM_RANGE: 64'hFF};
   localparam cvw_t CFG_L2 = '{AHBW: 64, PA_BITS: 32, RAM_LATENCY: 2, BURST_EN: 1'b1, UNCORE_RAM_RANGE: 64'hFF};

   localparam logic [63:0] PRE2 = 64'h1122_3344_5566_7788;
   localparam logic [63:0] PRE5 = 64'h5555_0000_0000_5555;

`ifdef AHB_RAM_BURST_EN
   localparam int BURST_CYCLES = 6;
`else
   localparam int BURST_CYCLES = 12;
`endif

   logic        hclk = 1'b0;
   logic        hresetn;
   logic [2:0]  sel;
   logic [31:0] haddr;
   logic        hwrite;
   logic [1:0]  htrans;
   logic [63:0] hwdata;
   logic [7:0]  hwstrb;
   logic [1:0]  act;
   logic        hready;
   logic [2:0]  rdy_vec;
   logic [2:0]  resp_v;
   logic [63:0] rdata_v [3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 hclk = ~hclk;

   assign hready = rdy_vec[act];

   ahb_latency_ram #(.P(CFG_L3)) u_l3 (
      .HCLK(hclk), .HRESETn(hresetn), .HSELRam(sel[0]), .HADDR(haddr), .HWRITE(hwrite),
      .HTRANS(htrans), .HREADY(hready), .HWDATA(hwdata), .HWSTRB(hwstrb),
      .HREADRam(rdata_v[0]), .HREADYRam(rdy_vec[0]), .HRESPRam(resp_v[0]));

   ahb_latency_ram #(.P(CFG_L0)) u_l0 (
      .HCLK(hclk), .HRESETn(hresetn), .HSELRam(sel[1]), .HADDR(haddr), .HWRITE(hwrite),
      .HTRANS(htrans), .HREADY(hready), .HWDATA(hwdata), .HWSTRB(hwstrb),
      .HREADRam(rdata_v[1]), .HREADYRam(rdy_vec[1]), .HRESPRam(resp_v[1]));

   ahb_latency_ram #(.P(CFG_L2)) u_l2 (
      .HCLK(hclk), .HRESETn(hresetn), .HSELRam(sel[2]), .HADDR(haddr), .HWRITE(hwrite),
      .HTRANS(htrans), .HREADY(hready), .HWDATA(hwdata), .HWSTRB(hwstrb),
      .HREADRam(rdata_v[2]), .HREADYRam(rdy_vec[2]), .HRESPRam(resp_v[2]));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      sel    = '0;
      htrans = AHB_IDLE;
      hwrite = 1'b0;
   endtask

   // Drive an address phase and hold it until accepted; returns cycles spent (1 = no stall).
   task automatic drive_addr(input string tag, input int idx, input logic [1:0] trans,
                             input logic wr, input logic [31:0] addr, output int n);
      logic rdy_now;
      act      = 2'(idx);
      sel      = '0;
      sel[idx] = 1'b1;
      htrans   = trans;
      hwrite   = wr;
      haddr    = addr;
      n        = 0;
      do begin
         rdy_now = hready;
         @(negedge hclk);
         n++;
      end while (!rdy_now && n < 64);
      check_eq({tag, "_acc"}, 64'(rdy_now), 64'd1);
   endtask

   // Wait out the current data phase; returns the number of wait-state cycles.
   task automatic finish_data(input string tag, output int n);
      n = 0;
      while (!hready && n < 64) begin
         @(negedge hclk);
         n++;
      end
      check_eq({tag, "_rdy"}, 64'(hready), 64'd1);
      @(negedge hclk);
   endtask

   task automatic single_write(input string tag, input int idx, input logic [31:0] addr,
                               input logic [63:0] data, input logic [7:0] strb);
      int n, w;
      drive_addr(tag, idx, AHB_NONSEQ, 1'b1, addr, n);
      hwdata = data;
      hwstrb = strb;
      bus_idle();
      finish_data(tag, w);
   endtask

   task automatic single_read(input string tag, input int idx, input logic [31:0] addr,
                              output logic [63:0] data, output int waits);
      int n;
      drive_addr(tag, idx, AHB_NONSEQ, 1'b0, addr, n);
      bus_idle();
      finish_data(tag, waits);
      data = rdata_v[idx];
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] rd;
      logic [63:0] bd [4];
      int n, w, total;

      hresetn = 1'b0;
      sel = '0; haddr = '0; hwrite = 1'b0; htrans = AHB_IDLE;
      hwdata = '0; hwstrb = '0; act = 2'd0;
      bd[0] = 64'h1111_2222_3333_4440;
      bd[1] = 64'h1111_2222_3333_4441;
      bd[2] = 64'h1111_2222_3333_4442;
      bd[3] = 64'h1111_2222_3333_4443;
      repeat (3) @(negedge hclk);

      // Reset values on every instance
      for (int k = 0; k < 3; k++) begin
         check_eq("rst_hready", 64'(rdy_vec[k]), 64'd1);
         check_eq("rst_hresp",  64'(resp_v[k]),  64'd0);
         check_eq("rst_hread",  rdata_v[k],      64'd0);
      end
      hresetn = 1'b1;
      @(negedge hclk);

      // L=3: preload word 2, reset again (contents survive), then timed NONSEQ read
      single_write("pre2", 0, 32'h8000_0010, PRE2, 8'hFF);
      single_write("pre5", 0, 32'h8000_0028, PRE5, 8'hFF);
      hresetn = 1'b0;
      @(negedge hclk);
      hresetn = 1'b1;
      check_eq("rst2_hread", rdata_v[0], 64'd0);
      drive_addr("l3_rd", 0, AHB_NONSEQ, 1'b0, 32'h8000_0010, n);
      check_eq("l3_rd_addr_cycles", 64'(n), 64'd1);
      bus_idle();
      for (int k = 1; k <= 3; k++) begin
         check_eq("l3_wait_hready", 64'(rdy_vec[0]), 64'd0);
         check_eq("l3_wait_hresp",  64'(resp_v[0]),  64'd0);
         @(negedge hclk);
      end
      check_eq("l3_done_hready", 64'(rdy_vec[0]), 64'd1);
      check_eq("l3_done_hread",  rdata_v[0],      PRE2);
      check_eq("l3_done_hresp",  64'(resp_v[0]),  64'd0);
      @(negedge hclk);

      // L=0: back-to-back partial write then read of the same word (forwarded)
      single_write("l0_pre", 1, 32'h8000_0010, 64'hA5A5_A5A5_5A5A_5A5A, 8'hFF);
      drive_addr("l0_wr", 1, AHB_NONSEQ, 1'b1, 32'h8000_0010, n);
      check_eq("l0_wr_cycles", 64'(n), 64'd1);
      hwdata = 64'hDEAD_BEEF_CAFE_F00D;
      hwstrb = 8'h0F;
      drive_addr("l0_rd", 1, AHB_NONSEQ, 1'b0, 32'h8000_0010, n);
      check_eq("l0_b2b_cycles", 64'(n), 64'd1);
      bus_idle();
      finish_data("l0_rd", w);
      check_eq("l0_rd_waits", 64'(w), 64'd0);
      check_eq("l0_fwd_data", rdata_v[1], 64'hA5A5_A5A5_CAFE_F00D);
      hwstrb = 8'h00;
      single_read("l0_rd2", 1, 32'h8000_0010, rd, w);
      check_eq("l0_committed", rd, 64'hA5A5_A5A5_CAFE_F00D);

      // L=2: INCR4 write burst, data-phase cycle count, then read back
      drive_addr("bst0", 2, AHB_NONSEQ, 1'b1, 32'h8000_0040, n);
      total = 0;
      for (int k = 1; k < 4; k++) begin
         hwdata = bd[k-1];
         hwstrb = 8'hFF;
         drive_addr("bstk", 2, AHB_SEQ, 1'b1, 32'h8000_0040 + 32'(8 * k), n);
         total += n;
      end
      hwdata = bd[3];
      bus_idle();
      finish_data("bst_end", w);
      total += w + 1;
      check_eq("burst_cycles", 64'(total), 64'(BURST_CYCLES));
      single_read("bst_rd1", 2, 32'h8000_0048, rd, w);
      check_eq("bst_rd1_waits", 64'(w), 64'd2);
      check_eq("bst_rd1_data", rd, bd[1]);
      single_read("bst_rd3", 2, 32'h8000_0058, rd, w);
      check_eq("bst_rd3_data", rd, bd[3]);

      // L=3: reset during the wait states of a write to word 5 drops the write
      drive_addr("rst_wr", 0, AHB_NONSEQ, 1'b1, 32'h8000_0028, n);
      hwdata = 64'hFFFF_FFFF_FFFF_FFFF;
      hwstrb = 8'hFF;
      bus_idle();
      check_eq("rst_wr_wait", 64'(rdy_vec[0]), 64'd0);
      hresetn = 1'b0;
      @(negedge hclk);
      hresetn = 1'b1;
      check_eq("rst_mid_hready", 64'(rdy_vec[0]), 64'd1);
      check_eq("rst_mid_hread",  rdata_v[0],      64'd0);
      single_read("rst_rd5", 0, 32'h8000_0028, rd, w);
      check_eq("rst_rd5_data", rd, PRE5);

      // IDLE / BUSY / unselected cycles: always ready, memory untouched
      act    = 2'd0;
      haddr  = 32'h8000_0028;
      hwdata = 64'h0BAD_0BAD_0BAD_0BAD;
      hwstrb = 8'hFF;
      for (int k = 0; k < 6; k++) begin
         hwrite = 1'b1;
         case (k % 3)
            0:       begin sel = 3'b001; htrans = AHB_IDLE;   end
            1:       begin sel = 3'b001; htrans = AHB_BUSY;   end
            default: begin sel = 3'b000; htrans = AHB_NONSEQ; end
         endcase
         @(negedge hclk);
         check_eq("idle_hready", 64'(rdy_vec[0]), 64'd1);
      end
      bus_idle();
      hwstrb = 8'h00;
      single_read("idle_rd5", 0, 32'h8000_0028, rd, w);
      check_eq("idle_rd5_data", rd, PRE5);
      check_eq("idle_rd5_waits", 64'(w), 64'd3);

      // Address bits above the range mask alias onto the same word
      single_read("alias_rd", 0, 32'hFFFF_FF10, rd, w);
      check_eq("alias_data", rd, PRE2);
      single_read("alias_rd2", 0, 32'h8000_0F28, rd, w);
      check_eq("alias_data2", rd, PRE5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
